vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator: pixel-strobe divider, h/v counters, registered syncs
// All pixel outputs are loaded together on the pix_en edge so they always describe the same pixel.
module vga_sync_gen #(
   parameter int H_DISP = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_DISP = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int HS_POL = 0,
   parameter int VS_POL = 0,
   parameter int DIV    = 2,
   parameter int CW     = 11
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          restart,
   output logic          pix_en,
   output logic          vga_hs,
   output logic          vga_vs,
   output logic          vga_blank,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);
   localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
   // One extra bit so sync-end bounds equal to the total still compare correctly.
   localparam logic [CW:0]   H_VIS    = (CW+1)'(H_DISP);
   localparam logic [CW:0]   H_SS     = (CW+1)'(H_DISP + H_FP);
   localparam logic [CW:0]   H_SE     = (CW+1)'(H_DISP + H_FP + H_SYNC);
   localparam logic [CW:0]   V_VIS    = (CW+1)'(V_DISP);
   localparam logic [CW:0]   V_SS     = (CW+1)'(V_DISP + V_FP);
   localparam logic [CW:0]   V_SE     = (CW+1)'(V_DISP + V_FP + V_SYNC);
   localparam logic          HS_ACT   = (HS_POL != 0);
   localparam logic          VS_ACT   = (VS_POL != 0);

   if ((H_TOT - 1) >= (1 << CW) || (V_TOT - 1) >= (1 << CW)) begin : g_cw_check
      $error("vga_sync_gen: CW too narrow for H_TOT-1 / V_TOT-1");
   end
   if (DIV < 1 || DIV > 16) begin : g_div_check
      $error("vga_sync_gen: DIV outside 1..16");
   end

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic          pix_en_q, pix_en_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic          tick;
   logic [CW:0]   h_ext, v_ext;

   always_comb begin
      tick          = (div_q == DIV_LAST);
      h_ext         = {1'b0, h_cnt_q};
      v_ext         = {1'b0, v_cnt_q};
      div_d         = div_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      x_d           = x_q;
      y_d           = y_q;
      de_d          = de_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      pix_en_d      = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (restart) begin
         div_d   = '0;
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else begin
         div_d    = tick ? '0 : div_q + DW'(1);
         pix_en_d = tick;
         if (tick) begin
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            de_d          = (h_ext < H_VIS) && (v_ext < V_VIS);
            hs_d          = ((h_ext >= H_SS) && (h_ext < H_SE)) ? HS_ACT : ~HS_ACT;
            vs_d          = ((v_ext >= V_SS) && (v_ext < V_SE)) ? VS_ACT : ~VS_ACT;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (h_cnt_q == H_LAST) begin
               h_cnt_d = '0;
               v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            end else begin
               h_cnt_d = h_cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q         <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         pix_en_q      <= 1'b0;
         de_q          <= 1'b0;
         hs_q          <= ~HS_ACT;
         vs_q          <= ~VS_ACT;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_en_q      <= pix_en_d;
         de_q          <= de_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_en      = pix_en_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign de          = de_q;
   assign vga_blank   = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
endmodule
